// File: rtl/fifo_rr_arbiter.sv
// Drains N upstream fifos into one registered valid/ready port, round-robin with optional burst lock.
// Latency: a pop in cycle t presents its beat on data_o from cycle t+1, at up to one beat per cycle.
// Backpressure: while valid_o is held and ready_i is low, nothing is popped and data_o/src_id_o stay stable.
module fifo_rr_arbiter #(
    parameter int N_SRC      = 4,
    parameter int DATA_WIDTH = 4,
    parameter int BURST_LEN  = 1
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic [N_SRC*DATA_WIDTH-1:0] fifo_data_i,
    input  logic [N_SRC-1:0]            fifo_empty_i,
    output logic [N_SRC-1:0]            fifo_pop_o,
    output logic [DATA_WIDTH-1:0]       data_o,
    output logic [$clog2(N_SRC)-1:0]    src_id_o,
    output logic                        valid_o,
    input  logic                        ready_i
);

    localparam int IDX_W = $clog2(N_SRC);
    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] rr_sel;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] grant;
    logic [CNT_W-1:0] cnt;
    logic             lock;
    logic             lock_hold;
    logic             gnt_valid;
    logic             load;
    logic             pop;

    // Walk downwards so the nearest non-empty source after last_grant wins;
    // last_grant itself (k == N_SRC) has the lowest priority.
    always_comb begin
        rr_sel = last_grant;
        cand   = '0;
        for (int k = N_SRC; k >= 1; k--) begin
            cand = IDX_W'((int'(last_grant) + k) % N_SRC);
            if (!fifo_empty_i[cand]) begin
                rr_sel = cand;
            end
        end
    end

    always_comb begin
        lock_hold  = lock && !fifo_empty_i[last_grant];
        grant      = lock_hold ? last_grant : rr_sel;
        gnt_valid  = |(~fifo_empty_i);
        load       = !valid_o || ready_i;
        pop        = load && gnt_valid;
        fifo_pop_o = '0;
        if (pop && rstn_i) begin
            fifo_pop_o = N_SRC'(1) << grant;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            last_grant <= IDX_W'(N_SRC - 1);
            cnt        <= '0;
            lock       <= 1'b0;
        end else if (pop) begin
            if (lock_hold) begin
                // cnt is non-zero whenever lock is set
                cnt  <= cnt - CNT_W'(1);
                lock <= (cnt != CNT_W'(1));
            end else begin
                last_grant <= grant;
                cnt        <= CNT_W'(BURST_LEN - 1);
                lock       <= (BURST_LEN > 1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_o  <= 1'b0;
            data_o   <= '0;
            src_id_o <= '0;
        end else if (load) begin
            valid_o <= gnt_valid;
            if (gnt_valid) begin
                data_o   <= fifo_data_i[grant*DATA_WIDTH +: DATA_WIDTH];
                src_id_o <= grant;
            end
        end
    end

endmodule

// File: doc/fifo_rr_arbiter.md
Name: fifo_rr_arbiter

Overview:
Downstream consumer of N fifo instances in the interconnect. Watches each fifo's empty flag and head data, pops one entry per cycle from the selected fifo using round-robin with optional burst lock, and presents the beat on a registered valid/ready master port. Source index travels with the data so the downstream slave can route responses.

Parameters:
N_SRC, 4, number of upstream fifos (>=2).
DATA_WIDTH, 4, beat width; matches the fifo DATA_WIDTH.
BURST_LEN, 1, max consecutive beats granted to one source before rotating (>=1; 1 = pure round-robin).

Ports:
clk_i  in  1  clock, rising edge
rstn_i  in  1  asynchronous active-low reset
fifo_data_i  in  N_SRC*DATA_WIDTH  head data of each fifo, packed, source i at [i*DATA_WIDTH +: DATA_WIDTH]
fifo_empty_i  in  N_SRC  empty flag per fifo
fifo_pop_o  out  N_SRC  pop strobe per fifo, one-hot or zero
data_o  out  DATA_WIDTH  registered output beat
src_id_o  out  $clog2(N_SRC)  index of the source that produced data_o
valid_o  out  1  data_o/src_id_o valid
ready_i  in  1  downstream accepts the beat when valid_o&&ready_i

Behaviour:
- Reset (async, rstn_i low): valid_o=0, data_o=0, src_id_o=0, burst counter=0, lock=0, last_grant=N_SRC-1 (first search starts at source 0). fifo_pop_o forced 0 while rstn_i low.
- load = !valid_o || ready_i (output register free or being drained this cycle).
- Candidate selection (combinational):
  - If lock && !fifo_empty_i[last_grant]: grant = last_grant.
  - Else: first i with !fifo_empty_i[i], searching last_grant+1, +2, ... modulo N_SRC, last_grant itself checked last.
  - gnt_valid = any fifo non-empty.
- fifo_pop_o[grant] = load && gnt_valid; never asserted for an empty fifo; at most one bit set.
- Data is sampled the same cycle as the pop (fifo head is combinational): on a clock edge with load=1: valid_o<=gnt_valid; if gnt_valid then data_o<=fifo_data_i[grant], src_id_o<=grant. With load=0, all output registers hold.
- Latency: pop in cycle t -> beat on data_o from cycle t+1. Sustained throughput 1 beat/cycle with ready_i=1.
- Burst lock, updated on each pop:
  - New selection (not locked): last_grant<=grant; cnt<=BURST_LEN-1; lock<=(BURST_LEN>1).
  - Locked continuation: cnt<=cnt-1; lock<=(cnt-1!=0).
  - Locked source empty at selection time: lock dropped, normal rotation resumes from last_grant+1.
  - No pop in a cycle: lock and cnt hold.
- Backpressure: valid_o=1, ready_i=0 -> no pop; data_o/src_id_o stable until accepted.
- Pop and accept in the same cycle are legal and give back-to-back beats.
- Wrap: index arithmetic modulo N_SRC; non-power-of-2 N_SRC is supported.
- Reset mid-operation: the held beat is discarded (valid_o=0 immediately), lock is cleared, rotation restarts at 0.

Test Plan:
(N_SRC=4, DATA_WIDTH=8 unless stated.)
- Reset: all fifos non-empty during reset -> fifo_pop_o=0, valid_o=0; first pop after release on source 0.
- Single source: fifo 2 holds 0xA0,0xA1,0xA2, ready_i=1 -> fifo_pop_o=4'b0100 for 3 consecutive cycles; data_o=0xA0,0xA1,0xA2 with src_id_o=2 on the following 3 cycles; then valid_o=0.
- Round-robin, BURST_LEN=1, all four fifos holding 2 entries -> src_id_o sequence 0,1,2,3,0,1,2,3, no bubbles.
- Burst, BURST_LEN=2, all fifos deep -> src_id_o sequence 0,0,1,1,2,2,3,3,0,0. Lock release: fifo 1 holds a single entry 0x11 and fifo 3 holds 0x30,0x31 -> 0x11 (src 1), then 0x30, 0x31 (src 3).
- Backpressure: valid_o=1 with data 0x55, ready_i=0 for 3 cycles -> fifo_pop_o=0, data_o stays 0x55. When ready_i returns to 1, next pop occurs in that same cycle and the next beat appears one cycle later.
- Mid-operation reset: rstn_i asserted while valid_o=1 and lock is active -> valid_o=0 asynchronously. After release, selection restarts at source 0 regardless of the prior grant.
